// File: rtl/regbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regbus_pkg
//  Description : Shared types and constants for the register-bus sequencer:
//                FSM state encoding, requester identifiers and the upper
//                bound on the number of registers sharing the bus.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package regbus_pkg;

   // Sequencer states. IDLE waits for a request, DRIVE/LATCH/HOLD walk one
   // valid transfer across the bus, GAP is the dead cycle carrying ACK.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      LATCH = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_e;

   // Requester identifiers, also used as bit positions in REQ/ACK.
   localparam int REQ_A = 0;
   localparam int REQ_B = 1;

   // Largest register bank the sequencer is built for.
   localparam int MAX_NREG = 16;

endpackage
`default_nettype wire

// File: rtl/regbus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : regbus_sequencer_if
//  Description : Bundle of request/acknowledge and register-bank control
//                signals between the control logic, the sequencer and the
//                register32 bank.
//  Ports       : REQ[1:0]           move request per requester (level)
//                SRC_A/DST_A        requester A source/destination index
//                SRC_B/DST_B        requester B source/destination index
//                ACK[1:0]           one-cycle completion pulse per requester
//                ERR                rejected-move flag, coincident with ACK
//                BUSY               sequencer not idle
//                N_OE[NREG-1:0]     per-register output enable, active-low
//                REG_CLK[NREG-1:0]  per-register latch clock, rising edge
//  Modports    : master - control side (drives requests)
//                slave  - sequencer side (drives acks and bank controls)
//  Revision    : 1.0  initial release
// ============================================================================
interface regbus_sequencer_if #(
   parameter int NREG = 8
);
   localparam int IDXW = $clog2(NREG);

   logic [1:0]      REQ;
   logic [IDXW-1:0] SRC_A;
   logic [IDXW-1:0] DST_A;
   logic [IDXW-1:0] SRC_B;
   logic [IDXW-1:0] DST_B;
   logic [1:0]      ACK;
   logic            ERR;
   logic            BUSY;
   logic [NREG-1:0] N_OE;
   logic [NREG-1:0] REG_CLK;

   modport master (
      output REQ, SRC_A, DST_A, SRC_B, DST_B,
      input  ACK, ERR, BUSY, N_OE, REG_CLK
   );

   modport slave (
      input  REQ, SRC_A, DST_A, SRC_B, DST_B,
      output ACK, ERR, BUSY, N_OE, REG_CLK
   );

endinterface
`default_nettype wire

// File: rtl/regbus_sequencer_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter with a request mask. The grant
//                is combinational; the priority pointer moves to the other
//                requester whenever a valid grant is accepted.
//  Ports       : clk        clock
//                rst_n      asynchronous active-low reset (pointer -> A)
//                req[1:0]   raw requests
//                mask[1:0]  requests to ignore this cycle
//                accept     grant consumed; advance the pointer
//                gnt_idx    granted requester (0 = A, 1 = B)
//                gnt_valid  at least one unmasked request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
   import regbus_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic [1:0] req,
   input  wire logic [1:0] mask,
   input  wire logic       accept,
   output logic            gnt_idx,
   output logic            gnt_valid
);

   logic       ptr;
   logic [1:0] eligible;

   always_comb begin
      eligible  = req & ~mask;
      gnt_valid = |eligible;
      // Contention goes to the pointer; otherwise the lone requester wins.
      if (eligible == 2'b11) begin
         gnt_idx = ptr;
      end else begin
         gnt_idx = eligible[REQ_B];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= 1'(REQ_A);
      end else if (accept && gnt_valid) begin
         ptr <= ~gnt_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/regbus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : regbus_sequencer
//  Description : Owns the shared 32-bit tristate bus of a register32 bank.
//                Serves register-to-register moves from two requesters with
//                round-robin arbitration, sequencing output enables and latch
//                clocks with break-before-make spacing:
//                   DRIVE (src enabled) -> LATCH (dst clock high)
//                   -> HOLD (src enabled, clocks low) -> GAP (all disabled,
//                   ACK). Out-of-range and self moves go straight to GAP.
//  Ports       : CLK    system clock
//                N_RST  asynchronous active-low reset
//                bus    regbus_sequencer_if.slave (REQ/SRC/DST in;
//                       ACK/ERR/BUSY/N_OE/REG_CLK out)
//  Revision    : 1.0  initial release
// ============================================================================
module regbus_sequencer
   import regbus_pkg::*;
#(
   parameter int NREG = 8
)(
   input  wire logic          CLK,
   input  wire logic          N_RST,
   regbus_sequencer_if.slave  bus
);

   localparam int IDXW = $clog2(NREG);
   // NREG widened by one bit so any index value can be compared against it.
   localparam logic [IDXW:0] NREG_W = NREG[IDXW:0];

   generate
      if (NREG < 2 || NREG > MAX_NREG) begin : g_bad_nreg
         $error("regbus_sequencer: NREG out of supported range");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State and transfer context
   // ------------------------------------------------------------------------
   state_e          state, state_nxt;
   logic [IDXW-1:0] src, src_nxt;
   logic [IDXW-1:0] dst, dst_nxt;
   logic            gnt, gnt_nxt;
   logic            rej, rej_nxt;

   // Registered outputs; every bank control comes straight from a flop.
   logic [NREG-1:0] n_oe, n_oe_nxt;
   logic [NREG-1:0] reg_clk, reg_clk_nxt;
   logic [1:0]      ack, ack_nxt;
   logic            err, err_nxt;
   logic            busy, busy_nxt;

   // Arbitration
   logic            arb_idx;
   logic            arb_valid;
   logic            arb_accept;
   logic [1:0]      arb_mask;
   logic [IDXW-1:0] cand_src;
   logic [IDXW-1:0] cand_dst;

   function automatic logic idx_ok(input logic [IDXW-1:0] idx);
      return {1'b0, idx} < NREG_W;
   endfunction

   rr_arbiter2 u_arb (
      .clk       (CLK),
      .rst_n     (N_RST),
      .req       (bus.REQ),
      .mask      (arb_mask),
      .accept    (arb_accept),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      src_nxt    = src;
      dst_nxt    = dst;
      gnt_nxt    = gnt;
      rej_nxt    = rej;
      arb_accept = 1'b0;
      arb_mask   = 2'b00;

      // The requester acknowledged in GAP still holds REQ for that cycle;
      // hide it so the same move is not granted twice.
      if (state == GAP) begin
         arb_mask[gnt] = 1'b1;
      end

      cand_src = arb_idx ? bus.SRC_B : bus.SRC_A;
      cand_dst = arb_idx ? bus.DST_B : bus.DST_A;

      case (state)
         IDLE, GAP: begin
            if (arb_valid) begin
               arb_accept = 1'b1;
               gnt_nxt    = arb_idx;
               src_nxt    = cand_src;
               dst_nxt    = cand_dst;
               if (!idx_ok(cand_src) || !idx_ok(cand_dst)) begin
                  rej_nxt   = 1'b1;
                  state_nxt = GAP;
               end else if (cand_src == cand_dst) begin
                  rej_nxt   = 1'b0;
                  state_nxt = GAP;
               end else begin
                  rej_nxt   = 1'b0;
                  state_nxt = DRIVE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         DRIVE:   state_nxt = LATCH;
         LATCH:   state_nxt = HOLD;
         HOLD:    state_nxt = GAP;
         default: state_nxt = IDLE;
      endcase

      // Outputs are decoded from the state being entered so that they can be
      // registered and still line up with that state.
      n_oe_nxt    = '1;
      reg_clk_nxt = '0;
      for (int i = 0; i < NREG; i++) begin
         if ((state_nxt == DRIVE || state_nxt == LATCH || state_nxt == HOLD) &&
             src_nxt == i[IDXW-1:0]) begin
            n_oe_nxt[i] = 1'b0;
         end
         if (state_nxt == LATCH && dst_nxt == i[IDXW-1:0]) begin
            reg_clk_nxt[i] = 1'b1;
         end
      end

      ack_nxt = 2'b00;
      if (state_nxt == GAP) begin
         ack_nxt[gnt_nxt] = 1'b1;
      end
      err_nxt  = (state_nxt == GAP) && rej_nxt;
      busy_nxt = (state_nxt != IDLE);
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Transfer context and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         src     <= '0;
         dst     <= '0;
         gnt     <= 1'(REQ_A);
         rej     <= 1'b0;
         n_oe    <= '1;
         reg_clk <= '0;
         ack     <= 2'b00;
         err     <= 1'b0;
         busy    <= 1'b0;
      end else begin
         src     <= src_nxt;
         dst     <= dst_nxt;
         gnt     <= gnt_nxt;
         rej     <= rej_nxt;
         n_oe    <= n_oe_nxt;
         reg_clk <= reg_clk_nxt;
         ack     <= ack_nxt;
         err     <= err_nxt;
         busy    <= busy_nxt;
      end
   end

   assign bus.N_OE    = n_oe;
   assign bus.REG_CLK = reg_clk;
   assign bus.ACK     = ack;
   assign bus.ERR     = err;
   assign bus.BUSY    = busy;

endmodule
`default_nettype wire

// File: tb/tb_regbus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regbus_sequencer
//  Description : Scoreboard bench for regbus_sequencer. Directed moves push
//                their expected completion into a queue; a monitor pops and
//                compares on every ACK, tracks the bus pattern of each
//                transfer, models the register bank and checks the one-hot
//                and break-before-make rules every cycle.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regbus_sequencer;

   localparam int NREG = 7;   // leaves index 7 as an out-of-range value
   localparam int IDXW = $clog2(NREG);

   logic clk;
   logic n_rst;

   regbus_sequencer_if #(.NREG(NREG)) bus ();

   regbus_sequencer #(.NREG(NREG)) dut (
      .CLK   (clk),
      .N_RST (n_rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ------------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------------
   typedef struct {
      logic [1:0] ack;
      logic       err;
      int         oe_idx;
      int         oe_cnt;
      int         clk_idx;
      int         clk_cnt;
      int         clk_pos;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input bit ok, input string name, input string detail);
      n_chk++;
      if (ok) n_pass++;
      else    $display("FAIL %s: %s", name, detail);
   endtask

   function automatic exp_t mk_valid(input logic [1:0] a, input int s, input int d);
      exp_t e;
      e.ack = a; e.err = 1'b0;
      e.oe_idx = s; e.oe_cnt = 3;
      e.clk_idx = d; e.clk_cnt = 1; e.clk_pos = 2;
      e.lat = 4;
      return e;
   endfunction

   function automatic exp_t mk_short(input logic [1:0] a, input logic er);
      exp_t e;
      e.ack = a; e.err = er;
      e.oe_idx = -1; e.oe_cnt = 0;
      e.clk_idx = -1; e.clk_cnt = 0; e.clk_pos = 0;
      e.lat = 1;
      return e;
   endfunction

   function automatic int low_idx(input logic [NREG-1:0] v);
      for (int i = 0; i < NREG; i++) begin
         if (!v[i]) return i;
      end
      return -1;
   endfunction

   // ------------------------------------------------------------------------
   // Monitor: register-bank model, invariants, per-transfer capture
   // ------------------------------------------------------------------------
   logic [31:0]     bank [NREG];
   logic [NREG-1:0] prev_noe;
   logic [NREG-1:0] prev_clk;
   int oe_idx, oe_cnt, clk_idx, clk_cnt, clk_pos, lat_cnt;

   initial begin
      exp_t e;
      int   cur;
      bit   ok;
      for (int i = 0; i < NREG; i++) bank[i] = 32'hA000_0000 + 32'(i);
      prev_noe = '1; prev_clk = '0;
      oe_idx = -1; oe_cnt = 0; clk_idx = -1; clk_cnt = 0; clk_pos = 0; lat_cnt = 0;
      forever begin
         @(negedge clk);
         ok = ($countones(~bus.N_OE) <= 1) &&
              ($countones(bus.REG_CLK) <= 1) &&
              (bus.REG_CLK == '0 || $countones(~bus.N_OE) == 1) &&
              !(prev_noe != '1 && bus.N_OE != '1 && bus.N_OE != prev_noe) &&
              (!bus.ERR || bus.ACK != 2'b00);
         chk(ok, "invariants", $sformatf("N_OE=%b prev_N_OE=%b REG_CLK=%b ACK=%b ERR=%b",
             bus.N_OE, prev_noe, bus.REG_CLK, bus.ACK, bus.ERR));
         if (!n_rst) begin
            oe_idx = -1; oe_cnt = 0; clk_idx = -1; clk_cnt = 0; clk_pos = 0; lat_cnt = 0;
         end else begin
            cur = low_idx(bus.N_OE);
            if (bus.BUSY) lat_cnt++;
            if (bus.N_OE != '1) begin
               oe_cnt++;
               oe_idx = cur;
            end
            if (bus.REG_CLK != '0) begin
               clk_cnt++;
               clk_idx = low_idx(~bus.REG_CLK);
               clk_pos = oe_cnt;
            end
            for (int i = 0; i < NREG; i++) begin
               if (bus.REG_CLK[i] && !prev_clk[i] && cur >= 0) bank[i] = bank[cur];
            end
            if (bus.ACK != 2'b00) begin
               if (sb.size() == 0) begin
                  chk(1'b0, "unexpected_ack", $sformatf("got ACK=%b ERR=%b, none expected",
                      bus.ACK, bus.ERR));
               end else begin
                  e = sb.pop_front();
                  chk(bus.ACK == e.ack && bus.ERR == e.err, "ack_err",
                      $sformatf("got ACK=%b ERR=%b, want ACK=%b ERR=%b",
                      bus.ACK, bus.ERR, e.ack, e.err));
                  chk(oe_idx == e.oe_idx && oe_cnt == e.oe_cnt && clk_idx == e.clk_idx &&
                      clk_cnt == e.clk_cnt && clk_pos == e.clk_pos, "bus_pattern",
                      $sformatf("got oe %0d x%0d clk %0d x%0d @%0d, want oe %0d x%0d clk %0d x%0d @%0d",
                      oe_idx, oe_cnt, clk_idx, clk_cnt, clk_pos,
                      e.oe_idx, e.oe_cnt, e.clk_idx, e.clk_cnt, e.clk_pos));
                  chk(lat_cnt == e.lat, "latency",
                      $sformatf("got %0d busy cycles, want %0d", lat_cnt, e.lat));
               end
               chk(bus.N_OE == '1 && bus.REG_CLK == '0, "gap_dead_cycle",
                   $sformatf("got N_OE=%b REG_CLK=%b in ACK cycle, want all-high/zero",
                   bus.N_OE, bus.REG_CLK));
               oe_idx = -1; oe_cnt = 0; clk_idx = -1; clk_cnt = 0; clk_pos = 0; lat_cnt = 0;
            end
         end
         prev_noe = bus.N_OE;
         prev_clk = bus.REG_CLK;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   // Requests na moves from A and nb from B; each requester keeps REQ high
   // until its last ACK and drops it on the edge that ends the ACK cycle.
   task automatic run_moves(input int sa, input int da, input int na,
                            input int sbx, input int db, input int nb);
      int ra, rb, cyc;
      bus.SRC_A = IDXW'(sa); bus.DST_A = IDXW'(da);
      bus.SRC_B = IDXW'(sbx); bus.DST_B = IDXW'(db);
      @(posedge clk); #1;
      bus.REQ = {nb > 0, na > 0};
      ra = na; rb = nb; cyc = 0;
      while ((ra > 0 || rb > 0) && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.ACK[0]) ra--;
         if (bus.ACK[1]) rb--;
         @(posedge clk); #1;
         if (ra <= 0) bus.REQ[0] = 1'b0;
         if (rb <= 0) bus.REQ[1] = 1'b0;
      end
      chk(ra <= 0 && rb <= 0, "ack_timeout",
          $sformatf("got %0d A and %0d B acks still outstanding, want 0", ra, rb));
      bus.REQ = 2'b00;
   endtask

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      int cyc;
      n_rst = 1'b0;
      bus.REQ = 2'b00;
      bus.SRC_A = '0; bus.DST_A = '0; bus.SRC_B = '0; bus.DST_B = '0;
      repeat (2) @(negedge clk);
      chk(bus.N_OE == '1 && bus.REG_CLK == '0 && bus.ACK == 2'b00 && !bus.ERR && !bus.BUSY,
          "reset_state", $sformatf("got N_OE=%b REG_CLK=%b ACK=%b ERR=%b BUSY=%b",
          bus.N_OE, bus.REG_CLK, bus.ACK, bus.ERR, bus.BUSY));
      @(posedge clk); #1;
      n_rst = 1'b1;
      repeat (2) @(posedge clk);

      // Single valid move A: 2 -> 5
      sb.push_back(mk_valid(2'b01, 2, 5));
      run_moves(2, 5, 1, 0, 0, 0);
      repeat (2) @(posedge clk);
      chk(bank[5] == 32'hA000_0002, "move_2_to_5",
          $sformatf("got reg5=%h, want a0000002", bank[5]));

      // Self move on B: ACK only, no bus activity; leaves pointer on A
      sb.push_back(mk_short(2'b10, 1'b0));
      run_moves(0, 0, 0, 3, 3, 1);
      repeat (2) @(posedge clk);

      // Both requesting continuously: A, B, A, B
      sb.push_back(mk_valid(2'b01, 1, 3));
      sb.push_back(mk_valid(2'b10, 4, 6));
      sb.push_back(mk_valid(2'b01, 1, 3));
      sb.push_back(mk_valid(2'b10, 4, 6));
      run_moves(1, 3, 2, 4, 6, 2);
      repeat (2) @(posedge clk);
      chk(bank[3] == 32'hA000_0001 && bank[6] == 32'hA000_0004, "alternating_moves",
          $sformatf("got reg3=%h reg6=%h, want a0000001 a0000004", bank[3], bank[6]));

      // Out-of-range source on A, out-of-range destination on B
      sb.push_back(mk_short(2'b01, 1'b1));
      run_moves(7, 1, 1, 0, 0, 0);
      repeat (2) @(posedge clk);
      sb.push_back(mk_short(2'b10, 1'b1));
      run_moves(0, 0, 0, 2, 7, 1);
      repeat (2) @(posedge clk);

      // Reset while in LATCH: move A 3 -> 0 abandoned without ACK
      bus.SRC_A = 3'd3; bus.DST_A = 3'd0;
      @(posedge clk); #1;
      bus.REQ = 2'b01;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.REG_CLK == '0 && cyc < 10);
      chk(bus.REG_CLK == 7'b0000001 && bus.N_OE == 7'b1110111, "reach_latch",
          $sformatf("got N_OE=%b REG_CLK=%b, want 1110111 0000001", bus.N_OE, bus.REG_CLK));
      #2 n_rst = 1'b0;
      #1;
      chk(bus.N_OE == '1 && bus.REG_CLK == '0 && bus.ACK == 2'b00 && !bus.BUSY, "async_reset",
          $sformatf("got N_OE=%b REG_CLK=%b ACK=%b BUSY=%b right after reset",
          bus.N_OE, bus.REG_CLK, bus.ACK, bus.BUSY));
      bus.REQ = 2'b00;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      repeat (2) @(posedge clk);

      // Pointer back on A after reset: A 4 -> 1 then B 6 -> 2
      sb.push_back(mk_valid(2'b01, 4, 1));
      sb.push_back(mk_valid(2'b10, 6, 2));
      run_moves(4, 1, 1, 6, 2, 1);
      repeat (3) @(posedge clk);
      chk(bank[1] == 32'hA000_0004 && bank[2] == 32'hA000_0004, "post_reset_moves",
          $sformatf("got reg1=%h reg2=%h, want a0000004 a0000004", bank[1], bank[2]));

      repeat (2) @(negedge clk);
      chk(sb.size() == 0, "scoreboard_drained",
          $sformatf("got %0d expected ACKs never seen, want 0", sb.size()));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
